spi_transaction_arbiter: RTL
============================

// Module: spi_transaction_arbiter
// PURPOSE
//  Shares one spi_master between NUM_REQUESTERS single-word clients (no burst).
//  Round-robin arbitration; latches the winner's command, drives spi_master
//  enable/rw/address/data, waits for the transfer to end, returns read data and
//  status to the winner. Sits between client FSMs and spi_master.
// PARAMETERS
//  NUM_REQUESTERS  4      number of clients (2..8)
//  DATA_WIDTH      16     spi_master data width
//  ADDRESS_WIDTH   15     spi_master address width
//  TIMEOUT_CYCLES  1024   max cycles from enable to busy-rise before error
// PORTS
//  clock                   in   1         system clock
//  reset                   in   1         asynchronous, active-high reset
//  request_valid           in   N         client i requests a transfer
//  request_read_write      in   N         1=read, 0=write, per client
//  request_address         in   N*AW      packed, client i at [i*AW +: AW]
//  request_data            in   N*DW      packed write data, client i at [i*DW +: DW]
//  request_ready           out  N         one-hot, 1-cycle pulse: command accepted
//  response_valid          out  N         one-hot, 1-cycle pulse: transfer done
//  response_data           out  DW        read data (0 for writes), valid with response_valid
//  response_error          out  1         timeout flag, valid with response_valid
//  master_enable           out  1         to spi_master.enable
//  master_read_write       out  1         to spi_master.read_write
//  master_address          out  AW        to spi_master.address
//  master_data             out  DW        to spi_master.data
//  master_burst_enable     out  1         tied 0
//  master_busy             in   1         from spi_master.busy
//  master_read_data        in   DW        from spi_master.read_data
//  master_read_data_valid  in   1         from spi_master.read_data_valid
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer = N-1 (client 0 wins first), timer 0.
//  Clients hold request_valid and fields stable until request_ready; dropping
//   valid before ready is allowed (request ignored if not seen in IDLE).
//  FSM: IDLE -> ISSUE -> WAIT_DONE -> RESPOND -> IDLE.
//  IDLE: if any request_valid, pick first set bit after rr pointer (wrapping);
//   latch rw/address/data, pulse request_ready[winner], pointer <= winner -> ISSUE.
//  ISSUE: master_enable=1 with latched fields; timer counts. master_busy=1 ->
//   drop enable, -> WAIT_DONE. timer reaches TIMEOUT_CYCLES-1 -> drop enable,
//   set error, -> RESPOND.
//  WAIT_DONE: capture master_read_data on master_read_data_valid (read only);
//   master_busy=0 -> RESPOND. No timeout here (spi_master always terminates).
//  RESPOND: pulse response_valid[winner] one cycle with response_data/error;
//   clear error/timer -> IDLE. response_data = 0 on write or error.
//  Latency: request_valid seen in IDLE -> request_ready next edge (1 cycle);
//   min 1 IDLE cycle between grants; back-to-back requesters alternate fairly.
//  Simultaneous requests: rr order only; new valids during a transfer wait.
//  master_address/data/rw held stable from ISSUE entry through RESPOND.
//  Reset mid-transfer: immediate return to reset state; no response issued.
// STRUCTURE
//  Package spi_arbiter_pkg: state_t enum {IDLE,ISSUE,WAIT_DONE,RESPOND},
//   TIMER_WIDTH = $clog2(TIMEOUT_CYCLES).
//  Sub-module round_robin_arbiter #(N): inputs request, pointer; output
//   one-hot grant + index; purely combinational.
// TESTING (bench: spi_master + spi_slave_sim_model, all 4 CPOL/CPHA modes)
//  Single write: client 1 wr addr 15'h0111 data 16'hA5A5 -> ready[1] 1 cycle
//   later, slave sees 16'hA5A5 @ 0x0111, response_valid[1], error=0, data=0.
//  Read back: client 2 rd 0x0111 -> response_valid[2], response_data=16'hA5A5.
//  Contention: clients 0,1,3 valid same cycle, held -> grants 0,1,3 in order,
//   then 0 again if re-requested; no overlap of master_enable with busy.
//  Timeout: force master_busy=0, TIMEOUT_CYCLES=16 -> response_error=1,
//   response_data=0, ready/response each exactly one pulse, FSM back to IDLE.
//  Reset mid-transfer: assert reset in WAIT_DONE -> outputs 0 same edge
//   (async), no response_valid; next request completes normally.
//  Fairness: all 4 valid continuously for 20 transfers -> each granted 5 times.

Source files
------------

// File: rtl/spi_transaction_arbiter_pkg.sv
// Shared types and sizing helpers for the SPI transaction arbiter.
package spi_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESPOND   = 2'd3
  } state_t;

  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;
  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES_DEFAULT);

  // Keeps the timer at least one bit wide for degenerate timeouts.
  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/spi_transaction_arbiter_if.sv
// Client request/response bundle plus the spi_master command/status signals.
interface spi_transaction_arbiter_if #(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDRESS_WIDTH  = 15
);

  logic [NUM_REQUESTERS-1:0]               request_valid;
  logic [NUM_REQUESTERS-1:0]               request_read_write;
  logic [NUM_REQUESTERS*ADDRESS_WIDTH-1:0] request_address;
  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]    request_data;
  logic [NUM_REQUESTERS-1:0]               request_ready;
  logic [NUM_REQUESTERS-1:0]               response_valid;
  logic [DATA_WIDTH-1:0]                   response_data;
  logic                                    response_error;
  logic                                    master_enable;
  logic                                    master_read_write;
  logic [ADDRESS_WIDTH-1:0]                master_address;
  logic [DATA_WIDTH-1:0]                   master_data;
  logic                                    master_burst_enable;
  logic                                    master_busy;
  logic [DATA_WIDTH-1:0]                   master_read_data;
  logic                                    master_read_data_valid;

  modport slave (
    input  request_valid, request_read_write, request_address, request_data,
    input  master_busy, master_read_data, master_read_data_valid,
    output request_ready, response_valid, response_data, response_error,
    output master_enable, master_read_write, master_address, master_data,
    output master_burst_enable
  );

  modport master (
    output request_valid, request_read_write, request_address, request_data,
    output master_busy, master_read_data, master_read_data_valid,
    input  request_ready, response_valid, response_data, response_error,
    input  master_enable, master_read_write, master_address, master_data,
    input  master_burst_enable
  );

endinterface

// File: rtl/spi_transaction_arbiter_round_robin_arbiter.sv
// Combinational round-robin pick: first requester after the pointer, wrapping.
module round_robin_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_index,
  output logic          grant_valid
);

  int            idx;
  logic [IW-1:0] idx_w;

  // Walk from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    idx         = 0;
    idx_w       = '0;
    for (int k = N; k >= 1; k--) begin
      idx   = (int'(pointer) + k) % N;
      idx_w = IW'(idx);
      if (request[idx_w]) begin
        grant        = '0;
        grant[idx_w] = 1'b1;
        grant_index  = idx_w;
        grant_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_transaction_arbiter.sv
// Shares one spi_master among single-word clients with round-robin arbitration.
// state     | meaning
// IDLE      | waiting for any request_valid; grant and latch winner's command
// ISSUE     | master_enable high, timing out if busy never rises
// WAIT_DONE | transfer running; capture read data, leave when busy falls
// RESPOND   | one-cycle response pulse to the winner
module spi_transaction_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDRESS_WIDTH  = 15,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                    clock,
  input logic                    reset,
  spi_transaction_arbiter_if.slave bus
);

  localparam int N  = NUM_REQUESTERS;
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = timer_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_next;
  logic [IW-1:0] pointer;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_index;
  logic          grant_valid;
  logic [N-1:0]  ready_q;
  logic          rw_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] rdata_q;
  logic          error_q;
  logic [TW-1:0] timer;
  logic          timeout;

  round_robin_arbiter #(.N(N)) u_rr (
    .request     (bus.request_valid),
    .pointer     (pointer),
    .grant       (grant),
    .grant_index (grant_index),
    .grant_valid (grant_valid)
  );

  assign timeout = (timer == TIMER_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (grant_valid) state_next = ISSUE;
      ISSUE: begin
        if (bus.master_busy) state_next = WAIT_DONE;
        else if (timeout)    state_next = RESPOND;
      end
      WAIT_DONE: if (!bus.master_busy) state_next = RESPOND;
      RESPOND:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Pointer doubles as the current winner until the next grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pointer <= IW'(N - 1);
      ready_q <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      timer   <= '0;
    end else begin
      ready_q <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            pointer <= grant_index;
            ready_q <= grant;
            rw_q    <= bus.request_read_write[grant_index];
            addr_q  <= bus.request_address[grant_index*AW +: AW];
            data_q  <= bus.request_data[grant_index*DW +: DW];
            rdata_q <= '0;
          end
        end
        ISSUE: begin
          timer <= timer + 1'b1;
          if (!bus.master_busy && timeout) error_q <= 1'b1;
        end
        WAIT_DONE: begin
          if (rw_q && bus.master_read_data_valid) rdata_q <= bus.master_read_data;
        end
        RESPOND: begin
          error_q <= 1'b0;
          timer   <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.request_ready  = ready_q;
    bus.response_valid = '0;
    bus.response_data  = '0;
    bus.response_error = 1'b0;
    bus.master_enable  = (state == ISSUE);
    if (state == RESPOND) begin
      bus.response_valid[pointer] = 1'b1;
      bus.response_error          = error_q;
      bus.response_data           = error_q ? '0 : rdata_q;
    end
  end

  assign bus.master_read_write   = rw_q;
  assign bus.master_address      = addr_q;
  assign bus.master_data         = data_q;
  assign bus.master_burst_enable = 1'b0;

endmodule
